// File: rtl/wb_pkg.sv
// wb_pkg: shared state, mode encodings and index helper for the Wishbone arbiter
package wb_pkg;
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} arb_state_t;
  localparam logic RR_FIXED = 1'b0;
  localparam logic RR_ROUND = 1'b1;
  localparam int PW = 3;
  function automatic logic [PW-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) idx |= oh[i] ? PW'(i) : '0;
    return idx;
  endfunction
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: one-hot fixed-priority or round-robin request picker
module wb_rr_pick
  import wb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_mode,
  output logic [N-1:0]  o_grant
);
  logic w_found;
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (i_mode == RR_ROUND) ? (int'(i_ptr) + 1 + i) % N : i;
      if (!w_found && i_req[j]) begin
        o_grant[j] = 1'b1;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: N-master to 1-slave pipelined Wishbone arbiter with bounded
// outstanding strobes and ack draining after the owner abandons its cycle.
module wb_arbiter_n
  import wb_pkg::*;
#(
  parameter int NMASTERS = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RR_MODE  = 0,
  parameter int MAX_OUT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NMASTERS-1:0]      m_cyc_i,
  input  logic [NMASTERS-1:0]      m_stb_i,
  input  logic [NMASTERS-1:0]      m_we_i,
  input  logic [NMASTERS*DW/8-1:0] m_sel_i,
  input  logic [NMASTERS*AW-1:0]   m_adr_i,
  input  logic [NMASTERS*DW-1:0]   m_dat_i,
  output logic [DW-1:0]            m_dat_o,
  output logic [NMASTERS-1:0]      m_ack_o,
  output logic [NMASTERS-1:0]      m_stall_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [DW/8-1:0]          s_sel_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  input  logic [DW-1:0]            s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_stall_i,
  output logic [NMASTERS-1:0]      grant_o,
  output logic                     busy_o
);
  localparam int SW = DW / 8;
  localparam int CW = $clog2(MAX_OUT + 1);
  arb_state_t r_state, w_state_nxt;
  logic [NMASTERS-1:0] r_grant, w_grant_nxt, w_pick;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic w_own, w_full, w_gcyc, w_gstb, w_gwe, w_inc, w_dec;
  logic [SW-1:0] w_gsel;
  logic [AW-1:0] w_gadr;
  logic [DW-1:0] w_gdat;

  wb_rr_pick #(.N(NMASTERS)) u_pick (
    .i_req  (m_cyc_i),
    .i_ptr  (r_ptr),
    .i_mode ((RR_MODE != 0) ? RR_ROUND : RR_FIXED),
    .o_grant(w_pick)
  );

  // one-hot AND-OR mux of the owner's request signals
  always_comb begin
    w_gcyc = 1'b0;
    w_gstb = 1'b0;
    w_gwe  = 1'b0;
    w_gsel = '0;
    w_gadr = '0;
    w_gdat = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      w_gcyc |= r_grant[k] & m_cyc_i[k];
      w_gstb |= r_grant[k] & m_stb_i[k];
      w_gwe  |= r_grant[k] & m_we_i[k];
      w_gsel |= {SW{r_grant[k]}} & m_sel_i[k*SW +: SW];
      w_gadr |= {AW{r_grant[k]}} & m_adr_i[k*AW +: AW];
      w_gdat |= {DW{r_grant[k]}} & m_dat_i[k*DW +: DW];
    end
  end

  assign w_own     = r_state == OWN;
  assign w_full    = r_cnt == CW'(MAX_OUT);
  assign s_cyc_o   = w_own ? w_gcyc : r_state == DRAIN;
  assign s_stb_o   = w_own & w_gcyc & w_gstb & ~w_full;
  assign s_we_o    = w_own & w_gwe;
  assign s_sel_o   = w_own ? w_gsel : '0;
  assign s_adr_o   = w_own ? w_gadr : '0;
  assign s_dat_o   = w_own ? w_gdat : '0;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = w_own ? r_grant & {NMASTERS{s_ack_i}} : '0;
  assign m_stall_o = w_own ? ~(r_grant & {NMASTERS{~(s_stall_i | w_full)}}) : '1;
  assign grant_o   = r_grant;
  assign busy_o    = r_state != IDLE;
  assign w_inc     = s_stb_o & ~s_stall_i;
  // acks with nothing outstanding are stale and must not underflow
  assign w_dec     = s_ack_i & (r_cnt != '0);
  assign w_cnt_nxt = r_cnt + CW'(w_inc) - CW'(w_dec);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: if (|m_cyc_i) begin
        w_state_nxt = OWN;
        w_grant_nxt = w_pick;
        w_ptr_nxt   = (RR_MODE != 0) ? onehot_to_idx(8'(w_pick)) : r_ptr;
      end
      OWN: if (!w_gcyc) begin
        w_state_nxt = (r_cnt == '0) ? IDLE : DRAIN;
        w_grant_nxt = (r_cnt == '0) ? '0 : r_grant;
      end
      DRAIN: if (w_cnt_nxt == '0) begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_ptr   <= PW'(NMASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_n.sv
// tb_wb_arbiter_n: fixed-priority (MAX_OUT=2) and round-robin (MAX_OUT=3) arbiters
// driven by shared stimulus and checked every cycle against a behavioural model.
module tb_wb_arbiter_n;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] cyc, stb, we;
  logic [N*4-1:0] sel;
  logic [N*32-1:0] adr, dat;
  logic [31:0] sdat;
  logic sack, sstall;
  logic [31:0] o_mdat[2], o_sadr[2], o_sdat[2];
  logic [N-1:0] o_ack[2], o_stall[2], o_grant[2];
  logic o_scyc[2], o_sstb[2], o_swe[2], o_busy[2];
  logic [3:0] o_ssel[2];
  int errors = 0, checks = 0;
  int ms[2], mg[2], mc[2], mp[2];
  logic [N-1:0] ord[4];

  for (genvar d = 0; d < 2; d++) begin : g
    wb_arbiter_n #(.NMASTERS(N), .AW(32), .DW(32), .RR_MODE(d), .MAX_OUT(2 + d)) u_dut (
      .clk_i(clk), .rst_i(rst_n),
      .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel), .m_adr_i(adr), .m_dat_i(dat),
      .m_dat_o(o_mdat[d]), .m_ack_o(o_ack[d]), .m_stall_o(o_stall[d]),
      .s_cyc_o(o_scyc[d]), .s_stb_o(o_sstb[d]), .s_we_o(o_swe[d]), .s_sel_o(o_ssel[d]),
      .s_adr_o(o_sadr[d]), .s_dat_o(o_sdat[d]), .s_dat_i(sdat), .s_ack_i(sack), .s_stall_i(sstall),
      .grant_o(o_grant[d]), .busy_o(o_busy[d])
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, a, e);
    end
  endtask

  // model: ms 0=idle 1=own 2=drain, mg owner index, mc outstanding, mp rr pointer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        ms[d] <= 0; mg[d] <= 0; mc[d] <= 0; mp[d] <= N - 1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int gi, nc, w;
        bit own;
        gi = mg[d];
        own = ms[d] == 1;
        nc = mc[d] + ((own && cyc[gi] && stb[gi] && mc[d] != 2 + d && !sstall) ? 1 : 0)
                   - ((sack && mc[d] > 0) ? 1 : 0);
        mc[d] <= nc;
        if (ms[d] == 0 && cyc != 0) begin
          w = -1;
          for (int i = 0; i < N; i++) begin
            int j;
            j = (d == 0) ? i : (mp[d] + 1 + i) % N;
            if (w < 0 && cyc[j]) w = j;
          end
          ms[d] <= 1; mg[d] <= w;
          if (d == 1) mp[d] <= w;
        end else if (own && !cyc[gi]) ms[d] <= (mc[d] == 0) ? 0 : 2;
        else if (ms[d] == 2 && nc == 0) ms[d] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int gi;
      bit own, full;
      gi = mg[d];
      own = ms[d] == 1;
      full = mc[d] == 2 + d;
      chk("m_dat", d, o_mdat[d], sdat);
      chk("s_cyc", d, 32'(o_scyc[d]), own ? 32'(cyc[gi]) : 32'(ms[d] == 2));
      chk("s_stb", d, 32'(o_sstb[d]), 32'(own && cyc[gi] && stb[gi] && !full));
      chk("s_we", d, 32'(o_swe[d]), 32'(own && we[gi]));
      chk("s_sel", d, 32'(o_ssel[d]), own ? 32'(sel[gi*4 +: 4]) : 0);
      chk("s_adr", d, o_sadr[d], own ? adr[gi*32 +: 32] : 0);
      chk("s_dat", d, o_sdat[d], own ? dat[gi*32 +: 32] : 0);
      chk("m_ack", d, 32'(o_ack[d]), (own && sack) ? 1 << gi : 0);
      chk("m_stall", d, 32'(o_stall[d]),
          own ? (((1 << gi) ^ 7) | ((sstall || full) ? 1 << gi : 0)) : 7);
      chk("grant", d, 32'(o_grant[d]), (ms[d] == 0) ? 0 : 1 << gi);
      chk("busy", d, 32'(o_busy[d]), 32'(ms[d] != 0));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0;
    sdat = '0; sack = 1'b0; sstall = 1'b0;
    ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", d, 32'(o_grant[d]), 0);
      chk("rst_stall", d, 32'(o_stall[d]), 32'h7);
      chk("rst_scyc", d, 32'(o_scyc[d]), 0);
      chk("rst_busy", d, 32'(o_busy[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step;
    // fixed priority: 1 beats 2, 2 granted after one idle cycle
    cyc = 3'b110;
    step;
    @(negedge clk);
    chk("A_grant", 0, 32'(o_grant[0]), 32'h2);
    chk("A_grant", 1, 32'(o_grant[1]), 32'h2);
    chk("A_stall", 0, 32'(o_stall[0]), 32'h5);
    cyc = 3'b100;
    step;
    @(negedge clk);
    chk("A_dead", 0, 32'(o_grant[0]), 0);
    chk("A_dead_busy", 0, 32'(o_busy[0]), 0);
    step;
    @(negedge clk);
    chk("A_next", 0, 32'(o_grant[0]), 32'h4);
    cyc = '0;
    step; step;
    // round-robin order with every master requesting
    for (int it = 0; it < 4; it++) begin
      cyc = 3'b111;
      step;
      @(negedge clk);
      chk("B_rr_grant", 1, 32'(o_grant[1]), 32'(ord[it]));
      stb = ord[it];
      step;
      stb = '0; sack = 1'b1;
      step;
      sack = 1'b0; cyc = 3'b111 & ~ord[it];
      step;
    end
    cyc = '0;
    step; step;
    // outstanding limit on the MAX_OUT=2 instance
    cyc = 3'b001;
    step;
    stb = 3'b001;
    @(negedge clk);
    chk("C_stb_first", 0, 32'(o_sstb[0]), 1);
    step; step;
    @(negedge clk);
    chk("C_full_stb", 0, 32'(o_sstb[0]), 0);
    chk("C_full_stall", 0, 32'(o_stall[0]), 32'h7);
    step; step;
    sack = 1'b1;
    @(negedge clk);
    chk("C_ack_cycle_stb", 0, 32'(o_sstb[0]), 0);
    step;
    sack = 1'b0;
    @(negedge clk);
    chk("C_reopen_stb", 0, 32'(o_sstb[0]), 1);
    chk("C_reopen_stall", 0, 32'(o_stall[0]), 32'h6);
    step;
    @(negedge clk);
    chk("C_refull_stb", 0, 32'(o_sstb[0]), 0);
    // same-cycle accept and ack at cnt=1
    stb = '0; sack = 1'b1;
    step;
    stb = 3'b001;
    @(negedge clk);
    chk("D_ack_owner", 0, 32'(o_ack[0]), 32'h1);
    chk("D_stb", 0, 32'(o_sstb[0]), 1);
    step;
    sack = 1'b0;
    @(negedge clk);
    chk("D_cnt_kept", 0, 32'(o_sstb[0]), 1);
    step;
    @(negedge clk);
    chk("D_cnt_two", 0, 32'(o_sstb[0]), 0);
    // owner abandons with two outstanding
    stb = '0; cyc = 3'b010;
    step;
    sack = 1'b1;
    @(negedge clk);
    chk("E_scyc", 0, 32'(o_scyc[0]), 1);
    chk("E_busy", 0, 32'(o_busy[0]), 1);
    chk("E_ack_swallow", 0, 32'(o_ack[0]), 0);
    chk("E_stall", 0, 32'(o_stall[0]), 32'h7);
    step;
    @(negedge clk);
    chk("E_ack_swallow2", 0, 32'(o_ack[0]), 0);
    chk("E_busy2", 0, 32'(o_busy[0]), 1);
    step;
    @(negedge clk);
    chk("E_idle", 0, 32'(o_busy[0]), 0);
    chk("E_idle_grant", 0, 32'(o_grant[0]), 0);
    step;
    sack = 1'b0;
    @(negedge clk);
    chk("E_next_grant", 0, 32'(o_grant[0]), 32'h2);
    cyc = '0;
    step; step;
    // asynchronous reset with three outstanding on the MAX_OUT=3 instance
    cyc = 3'b001;
    step;
    stb = 3'b001;
    step; step; step;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("F_grant", d, 32'(o_grant[d]), 0);
      chk("F_stall", d, 32'(o_stall[d]), 32'h7);
      chk("F_scyc", d, 32'(o_scyc[d]), 0);
      chk("F_sstb", d, 32'(o_sstb[d]), 0);
      chk("F_busy", d, 32'(o_busy[d]), 0);
    end
    stb = '0; cyc = '0; sack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    @(negedge clk);
    chk("F_late_ack", 1, 32'(o_ack[1]), 0);
    step;
    sack = 1'b0; cyc = 3'b001; stb = 3'b001;
    step; step; step; step;
    @(negedge clk);
    chk("F_cnt_clean_stb", 1, 32'(o_sstb[1]), 0);
    chk("F_cnt_clean_stall", 1, 32'(o_stall[1]), 32'h7);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        cyc[k] = cyc[k] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
        stb[k] = cyc[k] & 1'($urandom);
        we[k]  = 1'($urandom);
      end
      sel = 12'($urandom);
      adr = {$urandom(), $urandom(), $urandom()};
      dat = {$urandom(), $urandom(), $urandom()};
      sdat = $urandom();
      sack = $urandom_range(0, 2) == 0;
      sstall = $urandom_range(0, 3) == 0;
      step;
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    cyc = '0; stb = '0;
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
